cpu_hardcoded: RTL and testbench

- 8-bit multi-cycle CPU that runs a fixed 16-word program held in an internal ROM.
- A start/done/ack handshake frames each run.
- The program reads `sw` and `btn`, computes sw·(sw+1)/2 + btn (mod 256) and drives `ld` and four hex-digit nibbles `ssd0..ssd3`.
- Sits between the board I/O (switches, buttons, LEDs, 7-segment driver) and the top-level controller that issues start/ack.

---
 rtl/cpu_hardcoded.sv | 212 +++++++++++++++++++++
 tb/tb_cpu_hardcoded.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_hardcoded.sv
// cpu_hardcoded: 8-bit multi-cycle CPU running a fixed 16-word ROM program.
// The program computes sw*(sw+1)/2 + btn (mod 256) and writes it to the LEDs
// and to 7-segment digits 0/1. It also writes sw to digits 2/3.
// A start/done/ack handshake frames each run.
// Optional feature macro: CPU_INSTR_COUNT_EN. When defined, an instruction
// counter replaces OUT port 2 and is shown on {ssd3,ssd2} at HALT.
module cpu_hardcoded #(
    parameter int INSTRUC_SIZE = 32,
    parameter int ARG_SIZE     = 8,
    parameter int DATA_SIZE    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 ack,
    input  logic [3:0]           btn,
    input  logic [DATA_SIZE-1:0] sw,
    output logic                 done,
    output logic [DATA_SIZE-1:0] ld,
    output logic [3:0]           ssd0,
    output logic [3:0]           ssd1,
    output logic [3:0]           ssd2,
    output logic [3:0]           ssd3
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ARG_SIZE-1:0] OP_NOP  = 8'h00;
    localparam logic [ARG_SIZE-1:0] OP_LDI  = 8'h01;
    localparam logic [ARG_SIZE-1:0] OP_ADD  = 8'h02;
    localparam logic [ARG_SIZE-1:0] OP_SUB  = 8'h03;
    localparam logic [ARG_SIZE-1:0] OP_AND  = 8'h04;
    localparam logic [ARG_SIZE-1:0] OP_OR   = 8'h05;
    localparam logic [ARG_SIZE-1:0] OP_XOR  = 8'h06;
    localparam logic [ARG_SIZE-1:0] OP_IN   = 8'h07;
    localparam logic [ARG_SIZE-1:0] OP_OUT  = 8'h08;
    localparam logic [ARG_SIZE-1:0] OP_JMP  = 8'h09;
    localparam logic [ARG_SIZE-1:0] OP_BEQ  = 8'h0A;
    localparam logic [ARG_SIZE-1:0] OP_HALT = 8'h0B;

    // Packs one instruction word: opcode, A, B, C.
    function automatic logic [INSTRUC_SIZE-1:0] enc(
        input logic [ARG_SIZE-1:0] op,
        input logic [ARG_SIZE-1:0] a,
        input logic [ARG_SIZE-1:0] b,
        input logic [ARG_SIZE-1:0] c
    );
        return {op, a, b, c};
    endfunction

    state_t                r_state;
    logic [3:0]            r_pc;
    logic [DATA_SIZE-1:0]  r_regs [16];
    logic                  r_done;
    logic [DATA_SIZE-1:0]  r_ld;
    logic [3:0]            r_ssd0;
    logic [3:0]            r_ssd1;
    logic [3:0]            r_ssd2;
    logic [3:0]            r_ssd3;

    logic [INSTRUC_SIZE-1:0] w_instr;
    logic [ARG_SIZE-1:0]     w_op;
    logic [ARG_SIZE-1:0]     w_a;
    logic [ARG_SIZE-1:0]     w_b;
    logic [3:0]              w_c_idx;
    logic [DATA_SIZE-1:0]    w_rb;
    logic [DATA_SIZE-1:0]    w_rc;
    logic [DATA_SIZE-1:0]    w_in_val;

    // Hardcoded program ROM, indexed by the PC.
    always_comb begin
        w_instr = enc(OP_NOP, 8'd0, 8'd0, 8'd0);
        case (r_pc)
            4'd0:  w_instr = enc(OP_IN,   8'd0,  8'd0, 8'd0);
            4'd1:  w_instr = enc(OP_IN,   8'd1,  8'd1, 8'd0);
            4'd2:  w_instr = enc(OP_LDI,  8'd2,  8'd0, 8'd0);
            4'd3:  w_instr = enc(OP_LDI,  8'd3,  8'd0, 8'd0);
            4'd4:  w_instr = enc(OP_LDI,  8'd4,  8'd1, 8'd0);
            4'd5:  w_instr = enc(OP_BEQ,  8'd9,  8'd0, 8'd3);
            4'd6:  w_instr = enc(OP_ADD,  8'd2,  8'd2, 8'd0);
            4'd7:  w_instr = enc(OP_SUB,  8'd0,  8'd0, 8'd4);
            4'd8:  w_instr = enc(OP_JMP,  8'd5,  8'd0, 8'd0);
            4'd9:  w_instr = enc(OP_ADD,  8'd2,  8'd2, 8'd1);
            4'd10: w_instr = enc(OP_OUT,  8'd0,  8'd2, 8'd0);
            4'd11: w_instr = enc(OP_OUT,  8'd1,  8'd2, 8'd0);
            4'd12: w_instr = enc(OP_IN,   8'd5,  8'd0, 8'd0);
            4'd13: w_instr = enc(OP_OUT,  8'd2,  8'd5, 8'd0);
            4'd14: w_instr = enc(OP_HALT, 8'd0,  8'd0, 8'd0);
            4'd15: w_instr = enc(OP_HALT, 8'd0,  8'd0, 8'd0);
            default: ;
        endcase
    end

    assign w_op    = w_instr[INSTRUC_SIZE-1 -: ARG_SIZE];
    assign w_a     = w_instr[3*ARG_SIZE-1 -: ARG_SIZE];
    assign w_b     = w_instr[2*ARG_SIZE-1 -: ARG_SIZE];
    assign w_c_idx = w_instr[3:0];
    assign w_rb    = r_regs[w_b[3:0]];
    assign w_rc    = r_regs[w_c_idx];

    // Input port mux: port 0 = switches, port 1 = buttons, others read 0.
    always_comb begin
        w_in_val = '0;
        case (w_b)
            8'd0:    w_in_val = sw;
            8'd1:    w_in_val = {4'b0000, btn};
            default: w_in_val = '0;
        endcase
    end

`ifdef CPU_INSTR_COUNT_EN
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;

    // Saturating increment, so a long run pins the count at 0xFF.
    assign w_cnt_next = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
`endif

    // Control FSM, datapath and registered outputs in one clocked process.
    // NOTE: all state uses non-blocking assignments so every read in this block
    // sees the value from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_pc    <= '0;
            r_done  <= 1'b0;
            r_ld    <= '0;
            r_ssd0  <= '0;
            r_ssd1  <= '0;
            r_ssd2  <= '0;
            r_ssd3  <= '0;
            // NOTE: the register file is small and must read as zero after
            // reset, so it is cleared here rather than left to power-up values.
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
`ifdef CPU_INSTR_COUNT_EN
            r_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_state <= ST_EXEC;
                        for (int i = 0; i < 16; i++) r_regs[i] <= '0;
`ifdef CPU_INSTR_COUNT_EN
                        r_cnt <= '0;
`endif
                    end
                end

                ST_EXEC: begin
                    r_pc <= r_pc + 4'd1;
`ifdef CPU_INSTR_COUNT_EN
                    r_cnt <= w_cnt_next;
`endif
                    case (w_op)
                        OP_LDI: r_regs[w_a[3:0]] <= w_b;
                        OP_ADD: r_regs[w_a[3:0]] <= w_rb + w_rc;
                        OP_SUB: r_regs[w_a[3:0]] <= w_rb - w_rc;
                        OP_AND: r_regs[w_a[3:0]] <= w_rb & w_rc;
                        OP_OR:  r_regs[w_a[3:0]] <= w_rb | w_rc;
                        OP_XOR: r_regs[w_a[3:0]] <= w_rb ^ w_rc;
                        OP_IN:  r_regs[w_a[3:0]] <= w_in_val;
                        OP_OUT: begin
                            case (w_a)
                                8'd0: r_ld <= w_rb;
                                8'd1: {r_ssd1, r_ssd0} <= w_rb;
`ifndef CPU_INSTR_COUNT_EN
                                8'd2: {r_ssd3, r_ssd2} <= w_rb;
`endif
                                default: ;
                            endcase
                        end
                        OP_JMP: r_pc <= w_a[3:0];
                        OP_BEQ: begin
                            if (w_rb == w_rc) r_pc <= w_a[3:0];
                        end
                        OP_HALT: begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
`ifdef CPU_INSTR_COUNT_EN
                            {r_ssd3, r_ssd2} <= w_cnt_next;
`endif
                        end
                        default: ;
                    endcase
                end

                ST_DONE: begin
                    if (ack) begin
                        r_state <= ST_INIT;
                        r_done  <= 1'b0;
                    end
                end

                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign done = r_done;
    assign ld   = r_ld;
    assign ssd0 = r_ssd0;
    assign ssd1 = r_ssd1;
    assign ssd2 = r_ssd2;
    assign ssd3 = r_ssd3;

endmodule

// File: tb/tb_cpu_hardcoded.sv
// Self-checking bench for cpu_hardcoded: table of runs with a scoreboard
// queue, plus hand-written handshake, restart and reset sequences.
module tb_cpu_hardcoded;

    logic       clk;
    logic       reset;
    logic       start;
    logic       ack;
    logic [3:0] btn;
    logic [7:0] sw;
    logic       done;
    logic [7:0] ld;
    logic [3:0] ssd0, ssd1, ssd2, ssd3;

    cpu_hardcoded dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ack   (ack),
        .btn   (btn),
        .sw    (sw),
        .done  (done),
        .ld    (ld),
        .ssd0  (ssd0),
        .ssd1  (ssd1),
        .ssd2  (ssd2),
        .ssd3  (ssd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sw;
        logic [3:0] btn;
        logic [7:0] ld;        // also {ssd1,ssd0}
        logic [7:0] p2_plain;  // {ssd3,ssd2} without the counter
        logic [7:0] p2_cnt;    // {ssd3,ssd2} with the counter
        int         cycles;
    } vec_t;

    vec_t vecs [7];
    vec_t sb_q [$];
    vec_t last_exp;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_p2(input vec_t e);
`ifdef CPU_INSTR_COUNT_EN
        return e.p2_cnt;
`else
        return e.p2_plain;
`endif
    endfunction

    task automatic check_outputs(input string tag, input vec_t e);
        check({tag, "_ld"},   {24'd0, ld},   {24'd0, e.ld});
        check({tag, "_ssd0"}, {28'd0, ssd0}, {28'd0, e.ld[3:0]});
        check({tag, "_ssd1"}, {28'd0, ssd1}, {28'd0, e.ld[7:4]});
        check({tag, "_ssd2"}, {28'd0, ssd2}, {28'd0, exp_p2(e)[3:0]});
        check({tag, "_ssd3"}, {28'd0, ssd3}, {28'd0, exp_p2(e)[7:4]});
    endtask

    // Called at posedge+1 in INIT: drives start through one sampling edge.
    task automatic launch(input vec_t e);
        sw    = e.sw;
        btn   = e.btn;
        sb_q.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done rises, then scores the run.
    task automatic finish_run(input bit glitch);
        vec_t e;
        int   cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (glitch) begin
                if (cyc == 4) start = 1'b1;
                if (cyc == 5) start = 1'b0;
                if (cyc == 7) ack   = 1'b1;
                if (cyc == 8) ack   = 1'b0;
            end
        end
        start = 1'b0;
        ack   = 1'b0;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: got empty queue, expected a pending run");
        end else begin
            n_checks--;
            e = sb_q.pop_front();
            last_exp = e;
            check("run_cycles", cyc, e.cycles);
            check_outputs("run", e);
        end
    endtask

    // Holds done for a couple of cycles, then acknowledges.
    task automatic do_ack();
        repeat (2) @(posedge clk);
        #1;
        check("done_held", {31'd0, done}, 32'd1);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("done_after_ack", {31'd0, done}, 32'd0);
        check_outputs("retained", last_exp);
    endtask

    initial begin
        vec_t dummy;
        //          sw      btn    ld     p2_plain p2_cnt cycles
        vecs[0] = '{8'd0,   4'd0,  8'h00, 8'h00,   8'h0C, 12};
        vecs[1] = '{8'd10,  4'd0,  8'h37, 8'h0A,   8'h34, 52};
        vecs[2] = '{8'd4,   4'd3,  8'h0D, 8'h04,   8'h1C, 28};
        vecs[3] = '{8'd255, 4'd0,  8'h80, 8'hFF,   8'hFF, 1032};
        vecs[4] = '{8'd1,   4'd15, 8'h10, 8'h01,   8'h10, 16};
        vecs[5] = '{8'd20,  4'd5,  8'hD7, 8'h14,   8'h5C, 92};
        vecs[6] = '{8'd23,  4'd9,  8'h1D, 8'h17,   8'h68, 104};

        reset = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        sw    = 8'd0;
        btn   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        dummy = '{8'd0, 4'd0, 8'h00, 8'h00, 8'h00, 0};
        check_outputs("rst", dummy);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven runs.
        for (int i = 0; i < 7; i++) begin
            launch(vecs[i]);
            finish_run(1'b0);
            do_ack();
        end

        // start and ack pulsed during EXEC must not disturb the run.
        launch(vecs[1]);
        finish_run(1'b1);
        do_ack();

        // start held across ack: one cycle in INIT, then a new run.
        launch(vecs[4]);
        finish_run(1'b0);
        repeat (1) @(posedge clk);
        #1;
        sw    = 8'd2;
        btn   = 4'd1;
        sb_q.push_back('{8'd2, 4'd1, 8'h04, 8'h02, 8'h14, 20});
        ack   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("restart_done_low", {31'd0, done}, 32'd0);
        check_outputs("restart_retained", last_exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_run(1'b0);
        do_ack();

        // Reset in the middle of the loop aborts and clears outputs.
        launch(vecs[1]);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        dummy = sb_q.pop_front();
        check("midrst_done", {31'd0, done}, 32'd0);
        dummy = '{8'd0, 4'd0, 8'h00, 8'h00, 8'h00, 0};
        check_outputs("midrst", dummy);

        // Reset together with start: must stay in INIT.
        sw    = 8'd0;
        btn   = 4'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_start_idle_done", {31'd0, done}, 32'd0);

        // Recovery run after the aborted one.
        launch(vecs[1]);
        finish_run(1'b0);
        do_ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
